ls259_scan: RTL and testbench



---
 rtl/ls_pkg.sv | 32 +++
 rtl/ls259_chan.sv | 43 ++++
 rtl/ls259_scan.sv | 162 ++++++++++++++++
 tb/tb_ls259_scan.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared types for the ls259_scan addressable-latch slice.
// Holds the channel mode and scan-state enums, the slot count and related
// widths, and the decoder from the manual control pins to a channel mode.
package ls_pkg;

  localparam int unsigned SLOTS  = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {LATCH, HOLD, DEMUX, CLEAR} ls259_mode_e;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} ls259_scan_st_e;

  // Channel command as issued by the top-level mux.
  typedef struct packed {
    ls259_mode_e             mode;
    logic [ADDR_W-1:0]       addr;
  } ls259_ctrl_t;

  // 74LS259 truth table: clr_b selects clear-vs-keep, e_b gates the write.
  function automatic ls259_mode_e manual_mode(input logic clr_b, input logic e_b);
    ls259_mode_e m;
    case ({clr_b, e_b})
      2'b10:   m = LATCH;
      2'b11:   m = HOLD;
      2'b00:   m = DEMUX;
      default: m = CLEAR;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ls259_chan.sv
// One 4-bit addressable latch channel.
// Ports:
//   clk, rst_b  clock and asynchronous active-low reset
//   mode        LATCH / HOLD / DEMUX / CLEAR for this edge
//   addr        slot written in LATCH and DEMUX
//   d           serial data bit
//   q           registered slot contents
module ls259_chan
  import ls_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  ls259_mode_e       mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic              d,
  output logic [SLOTS-1:0]  q
);

  logic [SLOTS-1:0] q_q, q_d;

  // Next slot contents from the selected mode.
  always_comb begin
    q_d = q_q;
    case (mode)
      LATCH: q_d[addr] = d;
      HOLD:  q_d = q_q;
      DEMUX: begin
        q_d       = '0;
        q_d[addr] = d;
      end
      CLEAR: q_d = '0;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/ls259_scan.sv
// Dual 4-bit addressable latch with optional scan sequencer.
// The sequencer walks scan_sel over all slots of the companion 4:1 mux and
// captures da/db into both channels, waiting SETTLE cycles per slot.
// Build option: define LS259_SCAN_EN to compile the scan sequencer; without
// it the scan outputs are tied low and scan_start is ignored.
// Ports:
//   clk, rst_b           clock and asynchronous active-low reset
//   da, db               serial data per channel
//   S                    manual slot address
//   ea_b, eb_b           per-channel write enable (active-low)
//   clr_b                shared clear/demux control (active-low)
//   scan_start           one-cycle scan request
//   scan_sel             select to the companion mux
//   scan_busy, scan_done scan in progress / one-cycle completion pulse
//   Qa, Qb               channel registers
module ls259_scan #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      da,
  input  logic                      db,
  input  logic [ls_pkg::ADDR_W-1:0] S,
  input  logic                      ea_b,
  input  logic                      eb_b,
  input  logic                      clr_b,
  input  logic                      scan_start,
  output logic [ls_pkg::ADDR_W-1:0] scan_sel,
  output logic                      scan_busy,
  output logic                      scan_done,
  output logic [ls_pkg::SLOTS-1:0]  Qa,
  output logic [ls_pkg::SLOTS-1:0]  Qb
);

  import ls_pkg::ADDR_W;
  import ls_pkg::ls259_ctrl_t;
  import ls_pkg::manual_mode;

  ls259_ctrl_t ctrl_a_c, ctrl_b_c;

`ifdef LS259_SCAN_EN
  import ls_pkg::CNT_W;
  import ls_pkg::SLOTS;
  import ls_pkg::ls259_scan_st_e;

  ls259_scan_st_e      st_q, st_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // With zero settle cycles every slot goes straight to capture.
  function automatic ls259_scan_st_e slot_entry();
    return (SETTLE == 0) ? ls_pkg::CAPTURE : ls_pkg::SETTLE;
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st_q   <= ls_pkg::IDLE;
      cnt_q  <= '0;
      sel_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Scan sequencer next-state; a start coinciding with done is dropped.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (st_q)
      ls_pkg::IDLE: begin
        if (scan_start && !done_q) begin
          sel_d  = '0;
          busy_d = 1'b1;
          cnt_d  = CNT_W'(SETTLE);
          st_d   = slot_entry();
        end
      end
      ls_pkg::SETTLE: begin
        if (cnt_q <= CNT_W'(1)) st_d = ls_pkg::CAPTURE;
        else                    cnt_d = cnt_q - CNT_W'(1);
      end
      ls_pkg::CAPTURE: begin
        if (sel_q == ADDR_W'(SLOTS - 1)) begin
          st_d   = ls_pkg::IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          sel_d = sel_q + ADDR_W'(1);
          cnt_d = CNT_W'(SETTLE);
          st_d  = slot_entry();
        end
      end
      default: begin
        st_d   = ls_pkg::IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  // While busy the sequencer owns both channels; otherwise the pins do.
  always_comb begin
    ctrl_a_c.mode = manual_mode(clr_b, ea_b);
    ctrl_b_c.mode = manual_mode(clr_b, eb_b);
    ctrl_a_c.addr = S;
    ctrl_b_c.addr = S;
    if (busy_q) begin
      ctrl_a_c.mode = (st_q == ls_pkg::CAPTURE) ? ls_pkg::LATCH : ls_pkg::HOLD;
      ctrl_b_c.mode = ctrl_a_c.mode;
      ctrl_a_c.addr = sel_q;
      ctrl_b_c.addr = sel_q;
    end
  end

  assign scan_sel  = sel_q;
  assign scan_busy = busy_q;
  assign scan_done = done_q;
`else
  logic unused_scan;

  always_comb begin
    ctrl_a_c.mode = manual_mode(clr_b, ea_b);
    ctrl_b_c.mode = manual_mode(clr_b, eb_b);
    ctrl_a_c.addr = S;
    ctrl_b_c.addr = S;
  end

  assign unused_scan = ^{scan_start, 1'(SETTLE)};
  assign scan_sel    = '0;
  assign scan_busy   = 1'b0;
  assign scan_done   = 1'b0;
`endif

  ls259_chan u_chan_a (
    .clk   (clk),
    .rst_b (rst_b),
    .mode  (ctrl_a_c.mode),
    .addr  (ctrl_a_c.addr),
    .d     (da),
    .q     (Qa)
  );

  ls259_chan u_chan_b (
    .clk   (clk),
    .rst_b (rst_b),
    .mode  (ctrl_b_c.mode),
    .addr  (ctrl_b_c.addr),
    .d     (db),
    .q     (Qb)
  );

endmodule

// File: tb/tb_ls259_scan.sv
// Self-checking bench for ls259_scan: two instances (SETTLE=1 and SETTLE=0)
// share the manual pins; each has its own ls153-style mux feeding da/db
// from its own scan_sel while it is the scan target.
module tb_ls259_scan;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       da_m, db_m, ea_b, eb_b, clr_b, start, tgt, use_mux;
  logic [1:0] s;
  logic [3:0] ia, ib;

  logic       da_s1, db_s1, da_s0, db_s0, st_s1, st_s0;
  logic [1:0] sel_s1, sel_s0;
  logic       busy_s1, busy_s0, done_s1, done_s0;
  logic [3:0] qa_s1, qb_s1, qa_s0, qb_s0;

  logic [3:0] oqa [2];
  logic [3:0] oqb [2];
  logic [1:0] osel [2];
  logic       obusy [2];
  logic       odone [2];

  // Reference register image: mq[instance][channel].
  logic [3:0] mq [2][2];

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  // ls153 model: the scan target sees the mux output, the other sees the pins.
  assign da_s1 = (use_mux && !tgt) ? ia[sel_s1] : da_m;
  assign db_s1 = (use_mux && !tgt) ? ib[sel_s1] : db_m;
  assign da_s0 = (use_mux &&  tgt) ? ia[sel_s0] : da_m;
  assign db_s0 = (use_mux &&  tgt) ? ib[sel_s0] : db_m;
  assign st_s1 = start & ~tgt;
  assign st_s0 = start &  tgt;

  always_comb begin
    oqa[0] = qa_s1;  oqb[0] = qb_s1;  osel[0] = sel_s1;  obusy[0] = busy_s1;  odone[0] = done_s1;
    oqa[1] = qa_s0;  oqb[1] = qb_s0;  osel[1] = sel_s0;  obusy[1] = busy_s0;  odone[1] = done_s0;
  end

  ls259_scan #(.SETTLE(1)) u_dut (
    .clk(clk), .rst_b(rst_b), .da(da_s1), .db(db_s1), .S(s),
    .ea_b(ea_b), .eb_b(eb_b), .clr_b(clr_b), .scan_start(st_s1),
    .scan_sel(sel_s1), .scan_busy(busy_s1), .scan_done(done_s1),
    .Qa(qa_s1), .Qb(qb_s1)
  );

  ls259_scan #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_b(rst_b), .da(da_s0), .db(db_s0), .S(s),
    .ea_b(ea_b), .eb_b(eb_b), .clr_b(clr_b), .scan_start(st_s0),
    .scan_sel(sel_s0), .scan_busy(busy_s0), .scan_done(done_s0),
    .Qa(qa_s0), .Qb(qb_s0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Keep-or-clear the register, then write the addressed bit if enabled.
  function automatic logic [3:0] man(input logic [3:0] q, input logic clr, input logic e,
                                     input logic [1:0] a, input logic d);
    logic [3:0] r;
    r = clr ? q : 4'b0000;
    if (!e) r[a] = d;
    return r;
  endfunction

  task automatic model_manual(input int k);
    mq[k][0] = man(mq[k][0], clr_b, ea_b, s, da_m);
    mq[k][1] = man(mq[k][1], clr_b, eb_b, s, db_m);
  endtask

  task automatic check_q(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_qa%0d", tag, k), 32'(oqa[k]), 32'(mq[k][0]));
      chk($sformatf("%s_qb%0d", tag, k), 32'(oqb[k]), 32'(mq[k][1]));
    end
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_busy%0d", tag, k), 32'(obusy[k]), 32'd0);
      chk($sformatf("%s_done%0d", tag, k), 32'(odone[k]), 32'd0);
    end
  endtask

  task automatic man_op(input logic c, input logic ea, input logic eb, input logic [1:0] a,
                        input logic dva, input logic dvb, input string tag);
    clr_b = c;  ea_b = ea;  eb_b = eb;  s = a;  da_m = dva;  db_m = dvb;
    step();
    model_manual(0);
    model_manual(1);
    check_q(tag);
  endtask

`ifdef LS259_SCAN_EN
  // One full scan on instance t; junk drives random manual pins and a stray
  // start mid-scan, plus a start in the done cycle, all of which must be ignored.
  task automatic scan_run(input int t, input logic [3:0] iav, input logic [3:0] ibv,
                          input bit junk);
    int p;
    int last;
    int slot;
    int n_done;
    p      = (t == 0) ? 2 : 1;
    last   = 4 * p;
    n_done = 0;
    tgt = (t == 1);  ia = iav;  ib = ibv;  use_mux = 1'b1;
    clr_b = 1'b1;  ea_b = 1'b1;  eb_b = 1'b1;  start = 1'b1;
    step();
    start = 1'b0;
    chk("scan_busy_e0", 32'(obusy[t]), 32'd1);
    chk("scan_sel_e0",  32'(osel[t]),  32'd0);
    for (int e = 1; e <= last + 1; e++) begin
      if (junk && e < last) begin
        clr_b = 1'($urandom);  ea_b = 1'($urandom);  eb_b = 1'($urandom);
        s = 2'($urandom);  da_m = 1'($urandom);  db_m = 1'($urandom);
        start = (e == 2);
      end else begin
        clr_b = 1'b1;  ea_b = 1'b1;  eb_b = 1'b1;
        start = junk && (e == last + 1);
      end
      step();
      model_manual(1 - t);
      if (e <= last && (e % p) == 0) begin
        slot = e / p - 1;
        mq[t][0][slot] = iav[slot];
        mq[t][1][slot] = ibv[slot];
      end
      if (odone[t] === 1'b1) n_done++;
      chk($sformatf("scan%0d_sel_e%0d", t, e),  32'(osel[t]),  (e < last) ? 32'(e / p) : 32'd3);
      chk($sformatf("scan%0d_busy_e%0d", t, e), 32'(obusy[t]), 32'(e < last));
      chk($sformatf("scan%0d_done_e%0d", t, e), 32'(odone[t]), 32'(e == last));
      chk($sformatf("scan%0d_other_busy", t),  32'(obusy[1 - t]), 32'd0);
      check_q($sformatf("scan%0d_e%0d", t, e));
    end
    chk($sformatf("scan%0d_done_cnt", t), 32'(n_done), 32'd1);
    start = 1'b0;
    use_mux = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0;  da_m = 1'b0;  db_m = 1'b0;  ea_b = 1'b1;  eb_b = 1'b1;  clr_b = 1'b1;
    start = 1'b0;  tgt = 1'b0;  use_mux = 1'b0;  s = 2'd0;  ia = 4'd0;  ib = 4'd0;
    for (int k = 0; k < 2; k++) begin
      mq[k][0] = 4'd0;
      mq[k][1] = 4'd0;
    end

    step();
    step();
    check_q("rst_hold");
    check_idle("rst_hold");
    for (int k = 0; k < 2; k++) chk($sformatf("rst_sel%0d", k), 32'(osel[k]), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    step();
    check_q("rst_rel");
    check_idle("rst_rel");

    // Latch into slot 2, then hold while the data toggles.
    man_op(1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, "latch");
    chk("latch_qa_lit", 32'(qa_s1), 32'h4);
    for (int i = 0; i < 3; i++) man_op(1'b1, 1'b1, 1'b1, 2'd2, 1'(i), 1'(i + 1), "hold");

    // Fill channel A, then demux into slot 1, then clear both.
    for (int a = 0; a < 4; a++) man_op(1'b1, 1'b0, 1'b1, 2'(a), 1'b1, 1'b0, "fill");
    man_op(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, "demux");
    chk("demux_qa_lit", 32'(qa_s1), 32'h2);
    man_op(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, "clear");

    // Random manual traffic against the reference image.
    for (int i = 0; i < 60; i++) begin
      man_op(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), "rand");
      check_idle("rand");
    end

`ifdef LS259_SCAN_EN
    scan_run(0, 4'b1010, 4'b0110, 1'b0);
    chk("scan_qa_lit", 32'(qa_s1), 32'ha);
    chk("scan_qb_lit", 32'(qb_s1), 32'h6);
    for (int i = 0; i < 3; i++) scan_run(0, 4'($urandom), 4'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) scan_run(1, 4'($urandom), 4'($urandom), i != 0);

    // Reset shortly after edge 3 of a scan.
    tgt = 1'b0;  use_mux = 1'b1;  ia = 4'($urandom);  ib = 4'($urandom);
    clr_b = 1'b1;  ea_b = 1'b1;  eb_b = 1'b1;  start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_b = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      mq[k][0] = 4'd0;
      mq[k][1] = 4'd0;
      chk($sformatf("rstmid_sel%0d", k), 32'(osel[k]), 32'd0);
    end
    check_q("rstmid");
    check_idle("rstmid");
    @(negedge clk);
    rst_b = 1'b1;
    use_mux = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_q("post_rst");
      check_idle("post_rst");
    end
    scan_run(0, 4'($urandom), 4'($urandom), 1'b0);
`else
    // Scan disabled: start has no effect, manual modes keep working.
    for (int t = 0; t < 2; t++) begin
      tgt = 1'(t);
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
        man_op(1'b1, 1'b0, 1'b0, 2'(i), 1'($urandom), 1'($urandom), "noscan_latch");
        check_idle("noscan");
        chk($sformatf("noscan_sel%0d", t), 32'(osel[t]), 32'd0);
      end
      man_op(1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, "noscan_demux");
      chk("noscan_demux_lit", 32'(qa_s1), 32'h8);
      check_idle("noscan");
    end
    start = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
